wd279x_command_dispatch: RTL and testbench

- Front-end sequencer for the WD279x FDC. It latches writes to the command register and classifies each command as Type I, II/III or IV.
- Starts the Type I unit (restore/seek/step) or the Type II/III unit (read/write sector/track/address), and aborts them on Force Interrupt.
- Owns the single INTRQ line and the status-register view seen by the CPU.
- Sits between the CPU register decode and the command sub-units.

---
 rtl/wd279x_pkg.sv | 32 +++
 rtl/wd279x_irq_arm.sv | 80 ++++++++
 rtl/wd279x_command_dispatch.sv | 141 ++++++++++++++
 tb/tb_wd279x_command_dispatch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wd279x_pkg.sv
// Shared types and helpers for the WD279x command front end.
// Command classes, dispatcher states, Type IV flag positions and the classifier.
package wd279x_pkg;

    typedef enum logic [1:0] {
        CMD_T1,
        CMD_T23,
        CMD_T4
    } cmd_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_T1,
        ST_RUN_T23
    } dispatch_state_t;

    // Force Interrupt condition flags within the command byte.
    localparam int I0_BIT = 0;  // READY rising
    localparam int I1_BIT = 1;  // READY falling
    localparam int I2_BIT = 2;  // every index pulse
    localparam int I3_BIT = 3;  // immediate, sticky

    function automatic cmd_type_t classify_cmd(input logic [7:0] cmd);
        if (!cmd[7])
            return CMD_T1;
        else if (cmd[7:4] == 4'b1101)
            return CMD_T4;
        else
            return CMD_T23;
    endfunction

endpackage

// File: rtl/wd279x_irq_arm.sv
// Force Interrupt arm registers, INDEXn/READY synchronisers and edge detectors.
// Emits a one-cycle irq_event for an armed edge and a sticky level for the I3 arm.
module wd279x_irq_arm
    import wd279x_pkg::*;
#(
    parameter bit IDX_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       index_n,
    input  logic       ready,
    input  logic       arm_load,
    input  logic       arm_clear,
    input  logic [3:0] arm_flags,
    output logic       irq_event,
    output logic       sticky
);

    logic [3:0] arm;
    logic       idx_s;
    logic       rdy_s;
    logic       idx_prev;
    logic       rdy_prev;
    logic       idx_fall;
    logic       rdy_rise;
    logic       rdy_fall;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            arm <= 4'b0000;
        else if (arm_clear)
            arm <= 4'b0000;
        else if (arm_load)
            arm <= arm_flags;
    end

    if (IDX_SYNC) begin : g_sync
        logic [1:0] idx_ff;
        logic [1:0] rdy_ff;

        // Reset to the idle levels so release of reset never fakes an edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                idx_ff <= 2'b11;
                rdy_ff <= 2'b00;
            end else begin
                idx_ff <= {idx_ff[0], index_n};
                rdy_ff <= {rdy_ff[0], ready};
            end
        end

        assign idx_s = idx_ff[1];
        assign rdy_s = rdy_ff[1];
    end else begin : g_direct
        assign idx_s = index_n;
        assign rdy_s = ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_prev <= 1'b1;
            rdy_prev <= 1'b0;
        end else begin
            idx_prev <= idx_s;
            rdy_prev <= rdy_s;
        end
    end

    assign idx_fall  = idx_prev & ~idx_s;
    assign rdy_rise  = ~rdy_prev & rdy_s;
    assign rdy_fall  = rdy_prev & ~rdy_s;

    assign irq_event = (arm[I2_BIT] & idx_fall)
                     | (arm[I0_BIT] & rdy_rise)
                     | (arm[I1_BIT] & rdy_fall);
    assign sticky    = arm[I3_BIT];

endmodule

// File: rtl/wd279x_command_dispatch.sv
// WD279x command front end: latches and classifies commands, starts or aborts
// the Type I and Type II/III units, and owns INTRQ and the CPU status view.
module wd279x_command_dispatch
    import wd279x_pkg::*;
#(
    parameter bit IDX_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       MRn,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_wdata,
    input  logic       status_rd,
    input  logic       READY,
    input  logic       INDEXn,
    input  logic [7:0] t1_status,
    input  logic       t1_intrq,
    input  logic [7:0] t23_status,
    input  logic       t23_intrq,
    output logic [7:0] command,
    output logic       start_t1,
    output logic       start_t23,
    output logic       abort,
    output logic [7:0] status,
    output logic       INTRQ,
    output logic       busy
);

    dispatch_state_t state, state_next;
    cmd_type_t       last_type, last_type_next;
    cmd_type_t       wr_type;
    logic [7:0]      command_next;
    logic            start_t1_next;
    logic            start_t23_next;
    logic            abort_next;
    logic            intrq_next;
    logic            arm_load;
    logic            arm_clear;
    logic            irq_event;
    logic            sticky;
    logic            unit_done;
    logic [7:0]      status_src;
    logic            unused_status_msb;

    wd279x_irq_arm #(
        .IDX_SYNC (IDX_SYNC)
    ) u_irq_arm (
        .clk       (clk),
        .rst_n     (MRn),
        .index_n   (INDEXn),
        .ready     (READY),
        .arm_load  (arm_load),
        .arm_clear (arm_clear),
        .arm_flags (cmd_wdata[3:0]),
        .irq_event (irq_event),
        .sticky    (sticky)
    );

    assign wr_type = classify_cmd(cmd_wdata);

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        last_type_next = last_type;
        command_next   = command;
        start_t1_next  = 1'b0;
        start_t23_next = 1'b0;
        abort_next     = 1'b0;
        intrq_next     = INTRQ;
        arm_load       = 1'b0;
        arm_clear      = 1'b0;
        unit_done      = 1'b0;

        if (cmd_wr && wr_type == CMD_T4) begin
            // Force Interrupt wins over everything else in the same cycle.
            command_next = cmd_wdata;
            abort_next   = (state != ST_IDLE);
            if (state == ST_IDLE)
                last_type_next = CMD_T1;
            state_next = ST_IDLE;
            arm_load   = 1'b1;
            intrq_next = cmd_wdata[I3_BIT];
        end else if (cmd_wr && state == ST_IDLE) begin
            command_next   = cmd_wdata;
            last_type_next = wr_type;
            arm_clear      = 1'b1;
            intrq_next     = 1'b0;
            if (wr_type == CMD_T1) begin
                state_next    = ST_RUN_T1;
                start_t1_next = 1'b1;
            end else begin
                state_next     = ST_RUN_T23;
                start_t23_next = 1'b1;
            end
        end else begin
            case (state)
                ST_RUN_T1:  unit_done = t1_intrq;
                ST_RUN_T23: unit_done = t23_intrq;
                default:    unit_done = 1'b0;
            endcase
            if (unit_done)
                state_next = ST_IDLE;
            if (unit_done || irq_event)
                intrq_next = 1'b1;
            else if (status_rd && !sticky)
                intrq_next = 1'b0;
        end
    end

    // NOTE: only control state is reset; nothing here is a memory array.
    always_ff @(posedge clk or negedge MRn) begin
        if (!MRn) begin
            state     <= ST_IDLE;
            last_type <= CMD_T1;
            command   <= 8'h00;
            start_t1  <= 1'b0;
            start_t23 <= 1'b0;
            abort     <= 1'b0;
            INTRQ     <= 1'b0;
        end else begin
            state     <= state_next;
            last_type <= last_type_next;
            command   <= command_next;
            start_t1  <= start_t1_next;
            start_t23 <= start_t23_next;
            abort     <= abort_next;
            INTRQ     <= intrq_next;
        end
    end

    // Bit 7 always reflects the live drive-ready pin, not the unit's copy.
    always_comb begin
        status_src = (last_type == CMD_T23) ? t23_status : t1_status;
        status     = {~READY, status_src[6:1],
                      (state == ST_IDLE) ? 1'b0 : status_src[0]};
    end

    assign unused_status_msb = status_src[7];
    assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_wd279x_command_dispatch.sv
// Directed bench for wd279x_command_dispatch: a classification table plus
// hand-written sequences for ignore, abort, sticky, index and reset cases.
module tb_wd279x_command_dispatch;

    logic       clk;
    logic       MRn;
    logic       cmd_wr;
    logic [7:0] cmd_wdata;
    logic       status_rd;
    logic       READY;
    logic       INDEXn;
    logic [7:0] t1_status;
    logic       t1_intrq;
    logic [7:0] t23_status;
    logic       t23_intrq;
    logic [7:0] command;
    logic       start_t1;
    logic       start_t23;
    logic       abort;
    logic [7:0] status;
    logic       INTRQ;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] cmd;
        logic       st1;
        logic       st23;
        logic       bsy;
        logic [7:0] stat;
    } vec_t;

    vec_t vecs[6];

    wd279x_command_dispatch #(
        .IDX_SYNC (1'b1)
    ) dut (
        .clk        (clk),
        .MRn        (MRn),
        .cmd_wr     (cmd_wr),
        .cmd_wdata  (cmd_wdata),
        .status_rd  (status_rd),
        .READY      (READY),
        .INDEXn     (INDEXn),
        .t1_status  (t1_status),
        .t1_intrq   (t1_intrq),
        .t23_status (t23_status),
        .t23_intrq  (t23_intrq),
        .command    (command),
        .start_t1   (start_t1),
        .start_t23  (start_t23),
        .abort      (abort),
        .status     (status),
        .INTRQ      (INTRQ),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cmd(input logic [7:0] c);
        cmd_wr    = 1'b1;
        cmd_wdata = c;
        tick();
        cmd_wr    = 1'b0;
    endtask

    task automatic pulse_t1();
        t1_intrq = 1'b1;
        tick();
        t1_intrq = 1'b0;
    endtask

    task automatic pulse_t23();
        t23_intrq = 1'b1;
        tick();
        t23_intrq = 1'b0;
    endtask

    task automatic read_status();
        status_rd = 1'b1;
        tick();
        status_rd = 1'b0;
    endtask

    task automatic wait_intrq(input string name, input int budget);
        int k;
        k = 0;
        while (!INTRQ && k < budget) begin
            tick();
            k++;
        end
        check_b(name, INTRQ, 1'b1);
    endtask

    initial begin
        // status inputs chosen so bit0 and bit7 overrides are visible
        vecs[0] = '{8'h18, 1'b1, 1'b0, 1'b1, 8'h25};
        vecs[1] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h5A};
        vecs[2] = '{8'h7F, 1'b1, 1'b0, 1'b1, 8'h25};
        vecs[3] = '{8'hE4, 1'b0, 1'b1, 1'b1, 8'h5A};
        vecs[4] = '{8'hD0, 1'b0, 1'b0, 1'b0, 8'h24};
        vecs[5] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'h5A};

        MRn        = 1'b0;
        cmd_wr     = 1'b0;
        cmd_wdata  = 8'h00;
        status_rd  = 1'b0;
        READY      = 1'b1;
        INDEXn     = 1'b1;
        t1_status  = 8'h25;
        t1_intrq   = 1'b0;
        t23_status = 8'h5A;
        t23_intrq  = 1'b0;

        #3;
        check_v("reset_command", command, 8'h00);
        check_b("reset_start_t1", start_t1, 1'b0);
        check_b("reset_start_t23", start_t23, 1'b0);
        check_b("reset_abort", abort, 1'b0);
        check_b("reset_intrq", INTRQ, 1'b0);
        check_b("reset_busy", busy, 1'b0);
        check_v("reset_status", status, 8'h24);
        tick();
        tick();
        MRn = 1'b1;
        repeat (4) tick();

        // Classification table, each command run to completion.
        for (int i = 0; i < 6; i++) begin
            write_cmd(vecs[i].cmd);
            check_v($sformatf("tbl%0d_command", i), command, vecs[i].cmd);
            check_b($sformatf("tbl%0d_start_t1", i), start_t1, vecs[i].st1);
            check_b($sformatf("tbl%0d_start_t23", i), start_t23, vecs[i].st23);
            check_b($sformatf("tbl%0d_abort", i), abort, 1'b0);
            check_b($sformatf("tbl%0d_busy", i), busy, vecs[i].bsy);
            check_v($sformatf("tbl%0d_status", i), status, vecs[i].stat);
            tick();
            check_b($sformatf("tbl%0d_start_end", i), start_t1 | start_t23, 1'b0);
            if (vecs[i].bsy) begin
                if (vecs[i].st1) pulse_t1();
                else             pulse_t23();
                check_b($sformatf("tbl%0d_done_intrq", i), INTRQ, 1'b1);
                check_b($sformatf("tbl%0d_done_busy", i), busy, 1'b0);
                read_status();
                check_b($sformatf("tbl%0d_rd_clear", i), INTRQ, 1'b0);
            end
        end

        // Type II write and foreign completion ignored during RUN_T1.
        write_cmd(8'h18);
        tick();
        write_cmd(8'h80);
        check_b("ign_start_t23", start_t23, 1'b0);
        check_v("ign_command", command, 8'h18);
        check_v("ign_status", status, 8'h25);
        pulse_t23();
        check_b("ign_t23_busy", busy, 1'b1);
        check_b("ign_t23_intrq", INTRQ, 1'b0);
        pulse_t1();
        check_b("ign_done_intrq", INTRQ, 1'b1);
        check_b("ign_done_busy", busy, 1'b0);
        read_status();
        check_b("ign_rd_clear", INTRQ, 1'b0);

        // Set beats clear: completion and status read in the same cycle.
        write_cmd(8'h18);
        t1_intrq  = 1'b1;
        status_rd = 1'b1;
        tick();
        t1_intrq  = 1'b0;
        status_rd = 1'b0;
        check_b("setclr_intrq", INTRQ, 1'b1);
        read_status();
        check_b("setclr_rd_clear", INTRQ, 1'b0);

        // Force Interrupt D0 aborts a running Type II command.
        write_cmd(8'h80);
        check_b("abt_start_t23", start_t23, 1'b1);
        tick();
        write_cmd(8'hD0);
        check_b("abt_abort", abort, 1'b1);
        check_b("abt_busy", busy, 1'b0);
        check_b("abt_intrq", INTRQ, 1'b0);
        check_v("abt_command", command, 8'hD0);
        check_v("abt_status", status, 8'h5A);
        tick();
        check_b("abt_abort_end", abort, 1'b0);

        // D0 coinciding with the unit's own completion pulse.
        write_cmd(8'h80);
        tick();
        cmd_wr    = 1'b1;
        cmd_wdata = 8'hD0;
        t23_intrq = 1'b1;
        tick();
        cmd_wr    = 1'b0;
        t23_intrq = 1'b0;
        check_b("race_abort", abort, 1'b1);
        check_b("race_intrq", INTRQ, 1'b0);
        check_b("race_busy", busy, 1'b0);

        // Immediate sticky interrupt.
        write_cmd(8'hD8);
        check_b("d8_abort", abort, 1'b0);
        check_b("d8_intrq", INTRQ, 1'b1);
        read_status();
        check_b("d8_sticky", INTRQ, 1'b1);
        write_cmd(8'hD0);
        check_b("d8_cleared", INTRQ, 1'b0);

        // Interrupt on every index pulse.
        write_cmd(8'hD4);
        check_b("d4_no_intrq", INTRQ, 1'b0);
        for (int p = 0; p < 3; p++) begin
            INDEXn = 1'b0;
            wait_intrq($sformatf("d4_index%0d", p), 8);
            INDEXn = 1'b1;
            tick();
            read_status();
            check_b($sformatf("d4_rd_clear%0d", p), INTRQ, 1'b0);
            repeat (3) tick();
        end
        write_cmd(8'h00);
        check_b("d4_restore_start", start_t1, 1'b1);
        INDEXn = 1'b0;
        repeat (3) tick();
        INDEXn = 1'b1;
        repeat (6) tick();
        check_b("d4_disarmed", INTRQ, 1'b0);
        pulse_t1();
        check_b("d4_restore_done", busy, 1'b0);
        read_status();

        // Interrupt on READY rising only.
        write_cmd(8'hD1);
        READY = 1'b0;
        repeat (5) tick();
        check_b("d1_no_fall_irq", INTRQ, 1'b0);
        check_v("d1_status_notready", status, 8'hA4);
        READY = 1'b1;
        wait_intrq("d1_rise_irq", 8);
        write_cmd(8'hD0);
        check_b("d1_cleared", INTRQ, 1'b0);

        // Asynchronous reset in the middle of a Type I command.
        write_cmd(8'h18);
        tick();
        #2;
        MRn = 1'b0;
        #1;
        check_v("mr_command", command, 8'h00);
        check_b("mr_busy", busy, 1'b0);
        check_b("mr_start_t1", start_t1, 1'b0);
        check_b("mr_intrq", INTRQ, 1'b0);
        check_v("mr_status", status, 8'h24);
        tick();
        MRn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
